// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback bundle for regfile_mp_sb: packed read ports, two retire
// write ports, issue marking and the bulk-clear handshake.
interface regfile_mp_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wa_en;
  logic [ADDR_W-1:0]        wa_addr;
  logic [DATA_W-1:0]        wa_data;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     clr_start;
  logic                     clr_busy;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           iss_en, iss_addr, clr_start,
    input  rd_data, rd_busy, clr_busy
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           iss_en, iss_addr, clr_start,
    output rd_data, rd_busy, clr_busy
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write ports, busy-bit scoreboard and a
// sequential bulk-clear engine. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input logic             clk,
  input logic             rst_n,
  regfile_mp_sb_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] ra;
  logic              idle;
  logic              wa_ok;
  logic              wb_ok;
  logic              iss_ok;

  assign idle         = (state == IDLE);
  assign bus.clr_busy = (state == CLEAR);

  // Anything arriving while the clear engine runs is dropped, and r0 is inert when hardwired.
  assign wa_ok  = bus.wa_en  && idle && !((ZERO_REG != 0) && (bus.wa_addr  == '0));
  assign wb_ok  = bus.wb_en  && idle && !((ZERO_REG != 0) && (bus.wb_addr  == '0));
  assign iss_ok = bus.iss_en && idle && !((ZERO_REG != 0) && (bus.iss_addr == '0));

  always_comb begin
    busy_nxt = busy;
    if (wa_ok)  busy_nxt[bus.wa_addr]  = 1'b0;
    if (wb_ok)  busy_nxt[bus.wb_addr]  = 1'b0;
    if (iss_ok) busy_nxt[bus.iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy  <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
      busy[cnt] <= 1'b0;
      cnt       <= cnt + 1'b1;
      if (&cnt) state <= IDLE;
    end else begin
      if (wa_ok) regs[bus.wa_addr] <= bus.wa_data;
      if (wb_ok) regs[bus.wb_addr] <= bus.wb_data;
      busy <= busy_nxt;
      if (bus.clr_start) begin
        state <= CLEAR;
        cnt   <= '0;
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    ra          = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
      if (!((ZERO_REG != 0) && (ra == '0))) begin
        bus.rd_data[i*DATA_W +: DATA_W] = regs[ra];
        bus.rd_busy[i]                  = busy[ra];
`ifdef REGFILE_BYPASS_EN
        // wa_ok/wb_ok are already false during a clear, so forwarding stops there too.
        if (wb_ok && (bus.wb_addr == ra)) begin
          bus.rd_data[i*DATA_W +: DATA_W] = bus.wb_data;
          bus.rd_busy[i]                  = iss_ok && (bus.iss_addr == ra);
        end else if (wa_ok && (bus.wa_addr == ra)) begin
          bus.rd_data[i*DATA_W +: DATA_W] = bus.wa_data;
          bus.rd_busy[i]                  = iss_ok && (bus.iss_addr == ra);
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: vector table for writes/scoreboard plus
// hand sequences for async reset, forwarding and the bulk clear.
module tb_regfile_mp_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  regfile_mp_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  regfile_mp_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        wa_en;  logic [4:0] wa_addr;  logic [31:0] wa_data;
    logic        wb_en;  logic [4:0] wb_addr;  logic [31:0] wb_data;
    logic        iss_en; logic [4:0] iss_addr;
    logic [4:0]  ra0;    logic [4:0] ra1;
    logic [31:0] exp0;   logic [31:0] exp1;    logic [1:0] exp_busy;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wa_en = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.iss_en = 1'b0; bus.iss_addr = '0; bus.clr_start = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  initial begin
    int n;
    logic [31:0] exp_v;
    logic [4:0]  a0;
    logic [4:0]  a1;

    //                wa_en addr data          wb_en addr data          iss  addr  ra0 ra1  exp0          exp1          busy
    vecs[0] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  5'd0, 5'd1,  32'h0,        32'h0,        2'b00};
    vecs[1] = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22,       1'b0, 5'd0,  5'd7, 5'd0,  32'h22,       32'h0,        2'b00};
    vecs[2] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd9, 32'h99,       1'b0, 5'd0,  5'd3, 5'd9,  32'h33,       32'h99,       2'b00};
    vecs[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0,  5'd0, 5'd7,  32'h0,        32'h22,       2'b00};
    vecs[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd4,  5'd4, 5'd3,  32'h0,        32'h33,       2'b01};
    vecs[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h5,        1'b0, 5'd0,  5'd4, 5'd9,  32'h5,        32'h99,       2'b00};
    vecs[6] = '{1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 32'h0,        1'b1, 5'd4,  5'd4, 5'd4,  32'h44,       32'h44,       2'b11};
    vecs[7] = '{1'b1, 5'd12, 32'hC,       1'b1, 5'd4, 32'h55,       1'b0, 5'd0,  5'd4, 5'd12, 32'h55,       32'hC,        2'b00};
    vecs[8] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 5'd12, 5'd5, 32'hC,        32'hDEADBEEF, 2'b01};

    rst_n = 1'b0;
    idle_inputs();
    set_rd(5'd5, 5'd31);
    #12;
    chk("reset_rd0", bus.rd_data[31:0], 32'h0);
    chk("reset_rd1", bus.rd_data[63:32], 32'h0);
    chk("reset_busy", {30'h0, bus.rd_busy}, 32'h0);
    chk("reset_clr_busy", {31'h0, bus.clr_busy}, 32'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      bus.wa_en = vecs[i].wa_en; bus.wa_addr = vecs[i].wa_addr; bus.wa_data = vecs[i].wa_data;
      bus.wb_en = vecs[i].wb_en; bus.wb_addr = vecs[i].wb_addr; bus.wb_data = vecs[i].wb_data;
      bus.iss_en = vecs[i].iss_en; bus.iss_addr = vecs[i].iss_addr;
      step();
      idle_inputs();
      set_rd(vecs[i].ra0, vecs[i].ra1);
      #1;
      chk($sformatf("vec%0d_rd0", i), bus.rd_data[31:0], vecs[i].exp0);
      chk($sformatf("vec%0d_rd1", i), bus.rd_data[63:32], vecs[i].exp1);
      chk($sformatf("vec%0d_busy", i), {30'h0, bus.rd_busy}, {30'h0, vecs[i].exp_busy});
    end

    // Asynchronous reset mid-cycle: r5 holds 0xDEADBEEF, r12 is busy.
    set_rd(5'd5, 5'd12);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_r5", bus.rd_data[31:0], 32'h0);
    chk("async_rst_busy", {30'h0, bus.rd_busy}, 32'h0);
    #2;
    rst_n = 1'b1;
    step();

    // Forwarding: r6 holds 0x1111, then written with 0xABCD while being read.
    bus.wa_en = 1'b1; bus.wa_addr = 5'd6; bus.wa_data = 32'h1111;
    step();
    bus.wa_data = 32'hABCD;
    set_rd(5'd6, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_v = 32'hABCD;
`else
    exp_v = 32'h1111;
`endif
    chk("bypass_same_cycle", bus.rd_data[31:0], exp_v);
    chk("bypass_busy", {31'h0, bus.rd_busy[0]}, 32'h0);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd6;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_v = 32'h1;
`else
    exp_v = 32'h0;
`endif
    chk("bypass_busy_iss", {31'h0, bus.rd_busy[0]}, exp_v);
    step();
    idle_inputs();
    #1;
    chk("bypass_next_cycle", bus.rd_data[31:0], 32'hABCD);
    chk("iss_wins_busy", {31'h0, bus.rd_busy[0]}, 32'h1);

    // Bulk clear: fill with index, mark r20 busy, then clear.
    for (int i = 0; i < 32; i++) begin
      bus.wa_en = 1'b1; bus.wa_addr = 5'(i); bus.wa_data = 32'(i);
      step();
    end
    idle_inputs();
    bus.iss_en = 1'b1; bus.iss_addr = 5'd20;
    step();
    idle_inputs();
    set_rd(5'd31, 5'd20);
    #1;
    chk("fill_r31", bus.rd_data[31:0], 32'd31);
    chk("fill_r20_busy", {30'h0, bus.rd_busy}, 32'h2);
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    chk("clr_busy_rise", {31'h0, bus.clr_busy}, 32'h1);
    n = 0;
    while (bus.clr_busy && n < 40) begin
      if (n == 5) begin
        set_rd(5'd2, 5'd31);
        #1;
        chk("mid_clear_r2", bus.rd_data[31:0], 32'h0);
        chk("mid_clear_r31", bus.rd_data[63:32], 32'd31);
      end
      if (n == 10) begin
        bus.wa_en = 1'b1; bus.wa_addr = 5'd2; bus.wa_data = 32'h77;
      end
      if (n == 20) bus.clr_start = 1'b1;
      step();
      idle_inputs();
      n++;
    end
    chk("clr_busy_cycles", 32'(n), 32'd32);
    for (int i = 0; i < 16; i++) begin
      a0 = 5'(2 * i);
      a1 = 5'(2 * i + 1);
      set_rd(a0, a1);
      #1;
      chk($sformatf("cleared_r%0d", 2 * i), bus.rd_data[31:0], 32'h0);
      chk($sformatf("cleared_r%0d", 2 * i + 1), bus.rd_data[63:32], 32'h0);
      if (i == 10) chk("cleared_r20_busy", {30'h0, bus.rd_busy}, 32'h0);
    end

    // Reset in the middle of a clear returns the engine to idle.
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("pre_rst_clr_busy", {31'h0, bus.clr_busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_clear_rst_clr_busy", {31'h0, bus.clr_busy}, 32'h0);
    #1;
    rst_n = 1'b1;
    step();
    chk("after_rst_idle", {31'h0, bus.clr_busy}, 32'h0);
    bus.wa_en = 1'b1; bus.wa_addr = 5'd9; bus.wa_data = 32'h9;
    step();
    idle_inputs();
    set_rd(5'd9, 5'd0);
    #1;
    chk("write_after_rst", bus.rd_data[31:0], 32'h9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
